// File: rtl/coin_accumulator_pkg.sv
// Shared types for the coin accumulator and the vending FSM that consumes its credit.
// Holds the money type, the accumulator state encoding and the accepted denominations.
package coin_accumulator_pkg;

    localparam int unsigned MoneyW = 9;

    typedef logic [MoneyW-1:0] money_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold,
        StRefund
    } acc_state_e;

    localparam money_t Coin5   = 9'd5;
    localparam money_t Coin10  = 9'd10;
    localparam money_t Coin20  = 9'd20;
    localparam money_t Coin50  = 9'd50;
    localparam money_t Coin100 = 9'd100;

    function automatic logic is_denom(input money_t value);
        logic ok;
        case (value)
            Coin5, Coin10, Coin20, Coin50, Coin100: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin/credit/refund signal bundle between the coin front end and the accumulator.
// The slave modport is the accumulator; the master modport is its environment.
interface coin_accumulator_if;
    import coin_accumulator_pkg::*;

    logic   coin_valid_i;
    money_t coin_value_i;
    logic   insert_done_i;
    logic   cancel_i;
    logic   credit_ack_i;
    money_t credit_o;
    logic   credit_valid_o;
    logic   reject_o;
    money_t refund_o;
    logic   refund_valid_o;

    modport slave (
        input  coin_valid_i,
        input  coin_value_i,
        input  insert_done_i,
        input  cancel_i,
        input  credit_ack_i,
        output credit_o,
        output credit_valid_o,
        output reject_o,
        output refund_o,
        output refund_valid_o
    );

    modport master (
        output coin_valid_i,
        output coin_value_i,
        output insert_done_i,
        output cancel_i,
        output credit_ack_i,
        input  credit_o,
        input  credit_valid_o,
        input  reject_o,
        input  refund_o,
        input  refund_valid_o
    );

endinterface

// File: rtl/coin_accumulator_coin_validator.sv
// Combinational coin check: is the denomination legal, and does adding it stay within
// MAX_CREDIT. The sum is only meaningful when fits is set.
module coin_validator
    import coin_accumulator_pkg::*;
#(
    parameter money_t MAX_CREDIT = 9'd300
) (
    input  money_t value,
    input  money_t credit,
    output logic   denom_ok,
    output logic   fits,
    output money_t sum
);

    // One extra bit so the limit compare cannot be fooled by wrap-around.
    logic [MoneyW:0] wide_sum;

    always_comb begin
        denom_ok = is_denom(value);
        wide_sum = {1'b0, credit} + {1'b0, value};
        fits     = (wide_sum <= {1'b0, MAX_CREDIT});
        sum      = wide_sum[MoneyW-1:0];
    end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects coins into a credit, presents it to the vending FSM or refunds it.
// Optional idle auto-present is enabled with the COIN_ACC_TIMEOUT_EN macro.
module coin_accumulator
    import coin_accumulator_pkg::*;
#(
    parameter money_t      MAX_CREDIT     = 9'd300,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input logic               clk,
    input logic               rst,
    coin_accumulator_if.slave bus
);

    acc_state_e state_q, state_d;
    money_t     credit_q, credit_d;
    logic       reject_q, reject_d;

    logic   denom_ok;
    logic   fits;
    money_t sum;
    logic   accepting;
    logic   coin_accept;
    logic   done;

    coin_validator #(
        .MAX_CREDIT (MAX_CREDIT)
    ) u_validator (
        .value    (bus.coin_value_i),
        .credit   (credit_q),
        .denom_ok (denom_ok),
        .fits     (fits),
        .sum      (sum)
    );

    // A cancel in the same ACCUM cycle wins over the coin, which is then returned.
    always_comb begin
        accepting   = (state_q == StIdle) || ((state_q == StAccum) && !bus.cancel_i);
        coin_accept = bus.coin_valid_i && accepting && denom_ok && fits;
        reject_d    = bus.coin_valid_i && !coin_accept;
    end

`ifdef COIN_ACC_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        timeout;

    always_comb begin
        tmo_d   = tmo_q;
        timeout = 1'b0;
        if (coin_accept) begin
            tmo_d = TIMEOUT_CYCLES - 16'd1;
        end else if (state_q == StAccum) begin
            if (tmo_q == 16'd0) begin
                timeout = 1'b1;
            end else begin
                tmo_d = tmo_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign done = bus.insert_done_i || timeout;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign done               = bus.insert_done_i;
`endif

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        unique case (state_q)
            StIdle: begin
                if (coin_accept) begin
                    credit_d = sum;
                    state_d  = StAccum;
                end
            end
            StAccum: begin
                if (bus.cancel_i) begin
                    state_d = StRefund;
                end else begin
                    if (coin_accept) begin
                        credit_d = sum;
                    end
                    if (done) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.credit_ack_i) begin
                    credit_d = '0;
                    state_d  = StIdle;
                end
            end
            StRefund: begin
                credit_d = '0;
                state_d  = StIdle;
            end
            default: begin
                credit_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // All outputs decode from reset-cleared registers, so reset zeroes them without a clock.
    always_comb begin
        bus.credit_o       = credit_q;
        bus.credit_valid_o = (state_q == StHold);
        bus.reject_o       = reject_q;
        bus.refund_valid_o = (state_q == StRefund);
        bus.refund_o       = (state_q == StRefund) ? credit_q : '0;
    end

endmodule

// File: tb/tb_coin_accumulator.sv
// Scoreboard bench for coin_accumulator: directed coin sequences push expected events,
// a negedge monitor pops and compares whenever the DUT shows a credit/reject/hold/refund event.
module tb_coin_accumulator;
    import coin_accumulator_pkg::*;

    typedef enum logic [2:0] {EvCredit, EvReject, EvHold, EvRelease, EvRefund} ev_e;
    typedef struct packed {
        ev_e    kind;
        money_t value;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    ev_t  exp_q[$];

    money_t prev_credit;
    logic   prev_valid;

    coin_accumulator_if bus_if ();

    coin_accumulator #(
        .MAX_CREDIT     (9'd300),
        .TIMEOUT_CYCLES (16'd8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic observe(input ev_e kind, input money_t value);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_%s: got value %0d, required no event", kind.name(), value);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.value != value) begin
                mismatched++;
                $display("FAIL event: got %s=%0d, required %s=%0d",
                         kind.name(), value, e.kind.name(), e.value);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_credit <= '0;
            prev_valid  <= 1'b0;
        end else begin
            if (bus_if.credit_o != prev_credit) observe(EvCredit, bus_if.credit_o);
            if (bus_if.reject_o) observe(EvReject, bus_if.credit_o);
            if (bus_if.credit_valid_o && !prev_valid) observe(EvHold, bus_if.credit_o);
            else if (!bus_if.credit_valid_o && prev_valid) observe(EvRelease, bus_if.credit_o);
            if (bus_if.refund_valid_o) observe(EvRefund, bus_if.refund_o);
            else check("refund_idle_zero", int'(bus_if.refund_o), 0);
            prev_credit <= bus_if.credit_o;
            prev_valid  <= bus_if.credit_valid_o;
        end
    end

    task automatic push(input ev_e kind, input money_t value);
        exp_q.push_back('{kind: kind, value: value});
    endtask

    task automatic drive(input logic cv, input money_t val, input logic done,
                         input logic cancel, input logic ack);
        @(posedge clk);
        #1;
        bus_if.coin_valid_i  = cv;
        bus_if.coin_value_i  = val;
        bus_if.insert_done_i = done;
        bus_if.cancel_i      = cancel;
        bus_if.credit_ack_i  = ack;
    endtask

    task automatic coin(input money_t val);
        drive(1'b1, val, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_credit"}, int'(bus_if.credit_o), 0);
        check({tag, "_credit_valid"}, int'(bus_if.credit_valid_o), 0);
        check({tag, "_reject"}, int'(bus_if.reject_o), 0);
        check({tag, "_refund"}, int'(bus_if.refund_o), 0);
        check({tag, "_refund_valid"}, int'(bus_if.refund_valid_o), 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_if.coin_valid_i  = 1'b0;
        bus_if.coin_value_i  = '0;
        bus_if.insert_done_i = 1'b0;
        bus_if.cancel_i      = 1'b0;
        bus_if.credit_ack_i  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero("reset");
        #20;
        @(negedge clk);
        #2;
        rst = 1'b1;

        // 10 + 20 + 5, present, acknowledge
        coin(Coin10); push(EvCredit, 9'd10);
        coin(Coin20); push(EvCredit, 9'd30);
        coin(Coin5);  push(EvCredit, 9'd35);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); push(EvHold, 9'd35);
        idle(2);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1); push(EvCredit, 9'd0); push(EvRelease, 9'd0);
        idle(2);

        // ack and insert_done in IDLE do nothing; illegal coin is rejected
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        coin(9'd7); push(EvReject, 9'd0);
        idle(2);

        // fill to the limit, overflow coin rejected, then refund
        coin(Coin100); push(EvCredit, 9'd100);
        coin(Coin100); push(EvCredit, 9'd200);
        coin(Coin100); push(EvCredit, 9'd300);
        coin(Coin50);  push(EvReject, 9'd300);
        coin(Coin5);   push(EvReject, 9'd300);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); push(EvRefund, 9'd300); push(EvCredit, 9'd0);
        idle(3);

        // 50 + 20 then cancel
        coin(Coin50); push(EvCredit, 9'd50);
        coin(Coin20); push(EvCredit, 9'd70);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); push(EvRefund, 9'd70); push(EvCredit, 9'd0);
        idle(3);

        // coin together with insert_done; coin and cancel ignored in HOLD
        coin(Coin5); push(EvCredit, 9'd5);
        drive(1'b1, Coin10, 1'b1, 1'b0, 1'b0); push(EvCredit, 9'd15); push(EvHold, 9'd15);
        coin(Coin20); push(EvReject, 9'd15);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1); push(EvCredit, 9'd0); push(EvRelease, 9'd0);
        idle(2);

        // cancel with a coin: coin returned, prior credit refunded
        coin(Coin20); push(EvCredit, 9'd20);
        drive(1'b1, Coin50, 1'b0, 1'b1, 1'b0);
        push(EvReject, 9'd20); push(EvRefund, 9'd20); push(EvCredit, 9'd0);
        idle(3);

`ifdef COIN_ACC_TIMEOUT_EN
        coin(Coin20); push(EvCredit, 9'd20); push(EvHold, 9'd20);
        idle(7);
        @(posedge clk);
        #1;
        check("timeout_not_yet", int'(bus_if.credit_valid_o), 0);
        @(posedge clk);
        #1;
        check("timeout_valid", int'(bus_if.credit_valid_o), 1);
        check("timeout_credit", int'(bus_if.credit_o), 20);
        idle(1);
        reset_pulse("reset_hold");
        idle(2);
`else
        coin(Coin20); push(EvCredit, 9'd20);
        idle(20);
        check("no_timeout", int'(bus_if.credit_valid_o), 0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); push(EvRefund, 9'd20); push(EvCredit, 9'd0);
        idle(3);
        coin(Coin10); push(EvCredit, 9'd10);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); push(EvHold, 9'd10);
        idle(2);
        reset_pulse("reset_hold");
        idle(2);
`endif

        // reset mid-ACCUM discards credit without a refund
        coin(Coin50); push(EvCredit, 9'd50);
        idle(2);
        reset_pulse("reset_accum");
        idle(4);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/coin_accumulator.md
COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 Parameter MAX_CREDIT, default 9'd300, highest credit that may be accumulated.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd1000, idle cycles after the last coin before credit is auto-presented.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous, active-low.
REQ-005 Port coin_valid_i, input, 1, single-cycle strobe: one coin or note inserted.
REQ-006 Port coin_value_i, input, 9, denomination, sampled when coin_valid_i=1.
REQ-007 Port insert_done_i, input, 1, pulse: user finished inserting money.
REQ-008 Port cancel_i, input, 1, pulse: user aborts and requests a refund.
REQ-009 Port credit_ack_i, input, 1, pulse: downstream vending FSM has consumed the credit.
REQ-010 Port credit_o, output, 9, accumulated credit; drives the vending FSM money_i.
REQ-011 Port credit_valid_o, output, 1, credit_o is final and stable.
REQ-012 Port reject_o, output, 1, one-cycle pulse: the coin in this cycle was returned.
REQ-013 Port refund_o, output, 9, refund amount; valid while refund_valid_o=1.
REQ-014 Port refund_valid_o, output, 1, one-cycle refund pulse.

Function
REQ-015 States SHALL be: IDLE, ACCUM, HOLD, REFUND.
REQ-016 Valid denominations SHALL be 5, 10, 20, 50, 100; any other coin_value_i with coin_valid_i SHALL pulse reject_o the next cycle, with no credit change.
REQ-017 In IDLE or ACCUM, a valid coin SHALL add to credit_o the next cycle, IDLE->ACCUM.
REQ-018 A valid coin that makes credit exceed MAX_CREDIT SHALL be rejected (reject_o pulse) and credit held.
REQ-019 In ACCUM, insert_done_i SHALL go to HOLD; credit_valid_o=1 from the first HOLD cycle.
REQ-020 insert_done_i in IDLE (credit 0) SHALL be ignored.
REQ-021 A coin and insert_done_i in the same ACCUM cycle: the coin SHALL be processed first, and HOLD shows the updated credit.
REQ-022 In HOLD, credit_o SHALL stay stable; coins SHALL be rejected; cancel_i SHALL be ignored.
REQ-023 In HOLD, credit_ack_i SHALL clear credit_o to 0 and credit_valid_o to 0 the next cycle and return to IDLE; credit_ack_i outside HOLD SHALL be ignored.
REQ-024 cancel_i in ACCUM SHALL go to REFUND: refund_o=credit, refund_valid_o=1 for exactly one cycle, then credit=0 and return to IDLE.
REQ-025 cancel_i together with a coin in ACCUM: the coin SHALL be rejected and the prior credit refunded.
REQ-026 Arithmetic SHALL be 9-bit unsigned; overflow is impossible by REQ-018.
REQ-027 refund_o SHALL be 0 when refund_valid_o=0.

Reset
REQ-028 When rst=0, the state SHALL be IDLE and all outputs 0 immediately, with no clock required.
REQ-029 Reset mid-ACCUM or mid-HOLD SHALL discard credit without a refund pulse.

Configuration
REQ-030 Macro COIN_ACC_TIMEOUT_EN defined: a 16-bit counter SHALL reload on each accepted coin, and after TIMEOUT_CYCLES idle cycles in ACCUM SHALL behave as insert_done_i.
REQ-031 Macro COIN_ACC_TIMEOUT_EN undefined: there SHALL be no counter, and ACCUM is left only via insert_done_i or cancel_i.

Structure
REQ-032 A shared package SHALL hold the state enum, the denomination constants, and the 9-bit money type, for reuse by the vending FSM.
REQ-033 One sub-module, coin_validator, SHALL be used: a combinational denomination check plus the overflow check.

Verification
REQ-034 Coins 10, 20, 5 then insert_done_i -> credit_o=35, credit_valid_o=1; credit_ack_i -> credit_o=0, state IDLE.
REQ-035 Coin 7 -> reject_o pulse, credit_o unchanged at 0, state stays IDLE.
REQ-036 Coins 100, 100, 100, 50 with MAX_CREDIT=300 -> fourth coin rejected, credit_o=300.
REQ-037 Coins 50, 20 then cancel_i -> refund_o=70 with a one-cycle refund_valid_o, then credit_o=0.
REQ-038 Coin 10 and insert_done_i in the same cycle after credit 5 -> HOLD with credit_o=15; a coin inserted in HOLD -> reject_o.
REQ-039 With COIN_ACC_TIMEOUT_EN and TIMEOUT_CYCLES=8: coin 20, then 8 idle cycles -> credit_valid_o=1 with credit_o=20; reset asserted in HOLD -> all outputs 0 immediately.
